stdp_array: RTL and testbench

Multi-synapse, parametrised STDP learning engine: N_SYN presynaptic inputs converge on one postsynaptic input.
- Per-synapse pre-traces, one post-trace and per-synapse signed weights, all updated once per STDP tick.
- The tick comes from an internal clock prescaler; synapses are processed serially, one per clk.
- Adds fixed-point trace scaling, weight saturation, simultaneous-spike handling, a clean enable mode and a weight read-out port for the UART/debug path.

---
 rtl/stdp_array.sv | 175 +++++++++++++++++
 tb/tb_stdp_array.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/stdp_array.sv
// stdp_array: serial multi-synapse STDP learning engine.
// Pre/post traces and saturating signed weights, updated once per tick.
module stdp_array #(
  parameter int N_SYN           = 8,
  parameter int W_WIDTH         = 16,
  parameter int TRACE_WIDTH     = 18,
  parameter int TICK_DIV        = 6250,
  parameter int TAU_PLUS_SHIFT  = 4,
  parameter int TAU_MINUS_SHIFT = 7,
  parameter int A_PLUS_SHIFT    = 12,
  parameter int A_MINUS_SHIFT   = 9,
  parameter int W_INIT          = 0,
  parameter int W_MAX           = 2**(W_WIDTH-1)-1,
  parameter int W_MIN           = -(2**(W_WIDTH-1)),
  localparam int AW = (N_SYN > 1) ? $clog2(N_SYN) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [N_SYN-1:0]          pre_spike,
  input  logic                      post_spike,
  input  logic [AW-1:0]             rd_addr,
  output logic signed [W_WIDTH-1:0] rd_data,
  output logic                      tick,
  output logic                      busy,
  output logic                      overrun
);

  localparam int SW = W_WIDTH + 2;
  localparam int TW = TRACE_WIDTH;
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int NC = N_SYN + 1;

  localparam logic [TW-1:0] TRACE_ONE = TW'(1) << (TW - 2);
  localparam logic signed [SW-1:0] WMAX_E = SW'(W_MAX);
  localparam logic signed [SW-1:0] WMIN_E = SW'(W_MIN);
  localparam logic signed [W_WIDTH-1:0] WINIT_V = W_WIDTH'(W_INIT);
  localparam logic signed [W_WIDTH-1:0] WMAX_V = W_WIDTH'(W_MAX);
  localparam logic signed [W_WIDTH-1:0] WMIN_V = W_WIDTH'(W_MIN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    POST  = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // bit N_SYN carries the postsynaptic channel
  logic [NC-1:0] s1_q, s2_q, hist_q;
  logic [NC-1:0] pend_q, snap_q;
  logic [NC-1:0] rise;
  logic          overrun_q;
  logic signed [W_WIDTH-1:0] rd_q;

  logic [TW-1:0] x_q [N_SYN];
  logic [TW-1:0] y_q;
  logic signed [W_WIDTH-1:0] w_q [N_SYN];

  logic tick_idle, go;
  logic [TW-1:0] x_cur, x_new, y_new;
  logic signed [W_WIDTH-1:0] w_cur, w_new;
  logic signed [SW-1:0] dp, dm, sum;

  assign tick      = (cnt_q == CW'(TICK_DIV - 1));
  assign cnt_d     = tick ? '0 : cnt_q + 1'b1;
  assign busy      = (state_q != IDLE);
  assign tick_idle = tick & ~busy;
  assign go        = tick_idle & enable;
  assign rise      = s2_q & ~hist_q;
  assign overrun   = overrun_q;
  assign rd_data   = rd_q;

  // tick prescaler
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // synchronise, detect edges, collect pending spikes, snapshot on tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q      <= '1;
      s2_q      <= '1;
      hist_q    <= '1;
      pend_q    <= '0;
      snap_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      s1_q   <= {post_spike, pre_spike};
      s2_q   <= s1_q;
      hist_q <= s2_q;
      if (tick_idle) pend_q <= rise;
      else           pend_q <= pend_q | rise;
      if (go) snap_q <= pend_q;
      if (tick && busy) overrun_q <= 1'b1;
    end
  end

  // sweep controller state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // sweep controller next state
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          state_d = SWEEP;
          idx_d   = '0;
        end
      end
      SWEEP: begin
        if (idx_q == AW'(N_SYN - 1)) state_d = POST;
        else                         idx_d   = idx_q + 1'b1;
      end
      POST:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // per-synapse weight and trace update from pre-tick values
  always_comb begin
    x_cur = x_q[idx_q];
    w_cur = w_q[idx_q];
    dp    = $signed(SW'(x_cur >> A_PLUS_SHIFT));
    dm    = $signed(SW'(y_q >> A_MINUS_SHIFT));
    sum   = {{2{w_cur[W_WIDTH-1]}}, w_cur};
    if (snap_q[N_SYN]) sum = sum + dp;
    if (snap_q[idx_q]) sum = sum - dm;
    if (sum > WMAX_E)      w_new = WMAX_V;
    else if (sum < WMIN_E) w_new = WMIN_V;
    else                   w_new = sum[W_WIDTH-1:0];
    if (snap_q[idx_q]) x_new = TRACE_ONE;
    else               x_new = x_cur - (x_cur >> TAU_PLUS_SHIFT);
    if (snap_q[N_SYN]) y_new = TRACE_ONE;
    else               y_new = y_q - (y_q >> TAU_MINUS_SHIFT);
  end

  // trace and weight storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q <= '0;
      for (int i = 0; i < N_SYN; i++) begin
        x_q[i] <= '0;
        w_q[i] <= WINIT_V;
      end
    end else begin
      if (state_q == SWEEP) begin
        x_q[idx_q] <= x_new;
        w_q[idx_q] <= w_new;
      end
      if (state_q == POST) y_q <= y_new;
    end
  end

  // registered weight read-out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_q <= WINIT_V;
    else if ({1'b0, rd_addr} < (AW+1)'(N_SYN)) rd_q <= w_q[rd_addr];
    else rd_q <= '0;
  end

endmodule

// File: tb/tb_stdp_array.sv
// tb_stdp_array: directed and random spike patterns against a
// tick-level behavioural STDP model.
module tb_stdp_array;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b1;
  logic [3:0]        pre_spike = '0;
  logic              post_spike = 1'b0;
  logic [1:0]        rd_addr = '0;
  logic signed [15:0] rd_a, rd_b, rd_c;
  logic tick_a, busy_a, ovr_a;
  logic tick_b, busy_b, ovr_b;
  logic tick_c, busy_c, ovr_c;

  int checks = 0;
  int failures = 0;

  int xm [4];
  int ym;
  int wa [4];
  int wb [4];
  logic [3:0] cur_pm = '0;
  bit cur_ps = 1'b0;

  always #5 clk = ~clk;

  stdp_array #(.N_SYN(4), .TICK_DIV(16)) dut_a (
    .clk(clk), .rst(rst), .enable(enable),
    .pre_spike(pre_spike), .post_spike(post_spike),
    .rd_addr(rd_addr), .rd_data(rd_a),
    .tick(tick_a), .busy(busy_a), .overrun(ovr_a)
  );

  stdp_array #(.N_SYN(4), .TICK_DIV(16),
               .W_MAX(20), .W_MIN(-200)) dut_b (
    .clk(clk), .rst(rst), .enable(enable),
    .pre_spike(pre_spike), .post_spike(post_spike),
    .rd_addr(rd_addr), .rd_data(rd_b),
    .tick(tick_b), .busy(busy_b), .overrun(ovr_b)
  );

  stdp_array #(.N_SYN(4), .TICK_DIV(5)) dut_c (
    .clk(clk), .rst(rst), .enable(enable),
    .pre_spike(pre_spike), .post_spike(post_spike),
    .rd_addr(rd_addr), .rd_data(rd_c),
    .tick(tick_c), .busy(busy_c), .overrun(ovr_c)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic model_reset();
    ym = 0;
    for (int i = 0; i < 4; i++) begin
      xm[i] = 0;
      wa[i] = 0;
      wb[i] = 0;
    end
    cur_pm = '0;
    cur_ps = 1'b0;
  endtask

  task automatic model_tick(input bit en);
    int d;
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        d = 0;
        if (cur_ps) d = d + (xm[i] >> 12);
        if (cur_pm[i]) d = d - (ym >> 9);
        wa[i] = clamp(wa[i] + d, -32768, 32767);
        wb[i] = clamp(wb[i] + d, -200, 20);
        xm[i] = cur_pm[i] ? 65536 : xm[i] - (xm[i] >> 4);
      end
      ym = cur_ps ? 65536 : ym - (ym >> 7);
    end
    cur_pm = '0;
    cur_ps = 1'b0;
  endtask

  task automatic wait_tick(output int n);
    n = 1;
    @(negedge clk);
    while (tick_a !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("tick_seen", int'(tick_a), 1);
  endtask

  task automatic read_all();
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      @(negedge clk);
      check($sformatf("wA%0d", i), int'(rd_a), wa[i]);
      check($sformatf("wB%0d", i), int'(rd_b), wb[i]);
    end
  endtask

  task automatic step(input logic [3:0] pm, input bit ps, input bit en);
    int n;
    bit en_t;
    wait_tick(n);
    en_t = enable;
    model_tick(en_t);
    @(negedge clk);
    check("busy_sweep", int'(busy_a), int'(en_t));
    @(negedge clk);
    enable = en;
    pre_spike = pm;
    post_spike = ps;
    cur_pm = pm;
    cur_ps = ps;
    repeat (3) @(negedge clk);
    pre_spike = '0;
    post_spike = 1'b0;
    @(negedge clk);
    check("busy_done", int'(busy_a), 0);
    read_all();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d failures=%0d",
             checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    model_reset();
    rst = 1'b1;
    pre_spike = 4'hF;
    post_spike = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_rd", int'(rd_a), 0);
    check("rst_tick", int'(tick_a), 0);
    check("rst_busy", int'(busy_a), 0);
    check("rst_ovr", int'(ovr_a), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("ovr_c_early", int'(ovr_c), 0);
    pre_spike = '0;
    post_spike = 1'b0;
    wait_tick(n);
    model_tick(enable);
    wait_tick(n);
    check("tick_period", n, 16);
    model_tick(enable);

    // held-high inputs must not have counted; pure potentiation
    step(4'b0100, 1'b0, 1'b1);
    step(4'b0000, 1'b1, 1'b1);
    step(4'b0000, 1'b1, 1'b1);
    // depression twice, saturating dut_b at its floor
    step(4'b0010, 1'b0, 1'b1);
    step(4'b0010, 1'b0, 1'b1);
    step(4'b1001, 1'b1, 1'b1);
    // learning disabled across spikes, enable dropped mid-sweep
    step(4'b1111, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);

    // reset in the middle of a sweep
    wait_tick(n);
    @(negedge clk);
    @(negedge clk);
    check("busy_mid", int'(busy_a), 1);
    rst = 1'b1;
    #1;
    check("rst_mid_rd", int'(rd_a), 0);
    check("rst_mid_busy", int'(busy_a), 0);
    @(negedge clk);
    rst = 1'b0;
    enable = 1'b1;
    model_reset();
    read_all();

    // simultaneous pre and post with empty traces
    step(4'b1000, 1'b1, 1'b1);
    step(4'b0001, 1'b0, 1'b1);
    step(4'b0000, 1'b1, 1'b1);
    step(4'b0000, 1'b0, 1'b1);

    for (int k = 0; k < 40; k++) begin
      step(4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0));
    end
    step(4'b0000, 1'b0, 1'b1);

    check("ovr_a_final", int'(ovr_a), 0);
    check("ovr_c_final", int'(ovr_c), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
